intersection_sched: RTL and testbench

INTERSECTION_SCHED -- requirements
Module: intersection_sched

---
 rtl/sig_pkg.sv | 19 +
 rtl/phase_timer.sv | 20 ++
 rtl/intersection_sched.sv | 151 +++++++++++++++
 tb/tb_intersection_sched.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sig_pkg.sv
// rtl/sig_pkg.sv - shared state codes and light encodings for intersection_sched
// Contents: state_t (S0..S5, codes 0..5), light constants GREEN/YELLOW/RED (one-hot).
package sig_pkg;

    // S0 HG_CR, S1 HY_CR, S2 RR_TO_C, S3 HR_CG, S4 HR_CY, S5 RR_TO_H
    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5
    } state_t;

    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] RED    = 3'b100;

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - saturating phase timer with synchronous restart
// Ports: clock, clear (sync active-high), restart (zero on next edge), count [CNT_W-1:0].
module phase_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             restart,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clock) begin
        if (clear || restart) begin
            count <= '0;
        end else if (count != {CNT_W{1'b1}}) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/intersection_sched.sv
// rtl/intersection_sched.sv - highway/country-road light scheduler with pedestrian requests
// Ports: clock, clear (sync active-high), x (country car present), ped_req, ped_ack,
//        ped_walk, hwy[2:0], crd[2:0], state_o[2:0].
// Optional macro EMERGENCY_PREEMPT_EN adds preempt (in) and preempt_active (out).
module intersection_sched
    import sig_pkg::*;
#(
    parameter int MIN_GREEN     = 8,
    parameter int MAX_CRD_GREEN = 16,
    parameter int Y2R_CYCLES    = 3,
    parameter int R2G_CYCLES    = 2,
    parameter int CNT_W         = 5
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       x,
    input  logic       ped_req,
    output logic       ped_ack,
    output logic       ped_walk,
    output logic [2:0] hwy,
    output logic [2:0] crd,
`ifdef EMERGENCY_PREEMPT_EN
    input  logic       preempt,
    output logic       preempt_active,
`endif
    output logic [2:0] state_o
);

    // Last timer value of each phase; a phase ends when the timer reaches it.
    localparam logic [CNT_W-1:0] MIN_G_LAST = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_C_LAST = CNT_W'(MAX_CRD_GREEN - 1);
    localparam logic [CNT_W-1:0] Y2R_LAST   = CNT_W'(Y2R_CYCLES - 1);
    localparam logic [CNT_W-1:0] R2G_LAST   = CNT_W'(R2G_CYCLES - 1);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   timer;
    logic               restart;
    logic               ped_pend_q;
    logic               ped_pend_d;
    logic               clr_pend;
    logic               ped_accept;
    logic               force_pre;

`ifdef EMERGENCY_PREEMPT_EN
    always_ff @(posedge clock) begin
        if (clear) begin
            preempt_active <= 1'b0;
        end else begin
            preempt_active <= preempt;
        end
    end
    assign force_pre = preempt_active;
`else
    assign force_pre = 1'b0;
`endif

    // Timer restarts whenever the state is about to change, so it reads
    // zero in the first cycle of every state.
    assign restart = (state_d != state_q);

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clock   (clock),
        .clear   (clear),
        .restart (restart),
        .count   (timer)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q    <= S0;
            ped_pend_q <= 1'b0;
            ped_ack    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ped_pend_q <= ped_pend_d;
            ped_ack    <= ped_accept;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S0: begin
                if (!force_pre && (timer >= MIN_G_LAST) && (x || ped_pend_q)) begin
                    state_d = S1;
                end
            end
            S1: begin
                if (timer == Y2R_LAST) begin
                    state_d = S2;
                end
            end
            S2: begin
                // Under preemption the country phase is skipped; the pending
                // pedestrian request survives for the next round.
                if (timer == R2G_LAST) begin
                    state_d = force_pre ? S0 : S3;
                end
            end
            S3: begin
                if (force_pre || (!x && (timer >= MIN_G_LAST)) || (timer == MAX_C_LAST)) begin
                    state_d = S4;
                end
            end
            S4: begin
                if (timer == Y2R_LAST) begin
                    state_d = S5;
                end
            end
            S5: begin
                if (timer == R2G_LAST) begin
                    state_d = S0;
                end
            end
            default: state_d = S0;
        endcase
    end

    // Entering S3 serves the pending request. A request arriving in that
    // same cycle is acknowledged but does not re-arm the pending flag.
    always_comb begin
        clr_pend   = (state_q == S2) && (state_d == S3);
        ped_accept = ped_req && (!ped_pend_q || clr_pend || (state_q == S3));
        ped_pend_d = ped_pend_q;
        if (clr_pend) begin
            ped_pend_d = 1'b0;
        end else if (ped_req && !ped_pend_q && (state_q != S3)) begin
            ped_pend_d = 1'b1;
        end
    end

    always_comb begin
        hwy      = GREEN;
        crd      = RED;
        ped_walk = 1'b0;
        state_o  = state_q;
        case (state_q)
            S0: begin hwy = GREEN;  crd = RED;    end
            S1: begin hwy = YELLOW; crd = RED;    end
            S2: begin hwy = RED;    crd = RED;    end
            S3: begin hwy = RED;    crd = GREEN;  ped_walk = 1'b1; end
            S4: begin hwy = RED;    crd = YELLOW; end
            S5: begin hwy = RED;    crd = RED;    end
            default: begin hwy = GREEN; crd = RED; end
        endcase
    end

endmodule

// File: tb/tb_intersection_sched.sv
// tb/tb_intersection_sched.sv - self-checking bench for intersection_sched
module tb_intersection_sched;

    logic       clock = 1'b0;
    logic       clear;
    logic       x;
    logic       ped_req;
    logic       ped_ack;
    logic       ped_walk;
    logic [2:0] hwy;
    logic [2:0] crd;
    logic [2:0] state_o;
`ifdef EMERGENCY_PREEMPT_EN
    logic       preempt;
    logic       preempt_active;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       clr;
        logic       x;
        logic       req;
        logic [2:0] st;
        logic       ack;
    } vec_t;

    typedef struct {
        logic [2:0] st;
        logic [2:0] hwy;
        logic [2:0] crd;
        logic       walk;
        logic       ack;
        string      tag;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    intersection_sched dut (
        .clock          (clock),
        .clear          (clear),
        .x              (x),
        .ped_req        (ped_req),
        .ped_ack        (ped_ack),
        .ped_walk       (ped_walk),
        .hwy            (hwy),
        .crd            (crd),
`ifdef EMERGENCY_PREEMPT_EN
        .preempt        (preempt),
        .preempt_active (preempt_active),
`endif
        .state_o        (state_o)
    );

    always #5 clock = ~clock;

    function automatic logic [5:0] lights(input logic [2:0] st);
        case (st)
            3'd0:    return {3'b001, 3'b100};
            3'd1:    return {3'b010, 3'b100};
            3'd2:    return {3'b100, 3'b100};
            3'd3:    return {3'b100, 3'b001};
            3'd4:    return {3'b100, 3'b010};
            3'd5:    return {3'b100, 3'b100};
            default: return {3'b001, 3'b100};
        endcase
    endfunction

    // Expected state for a full cycle: S1 entered at t_s1, S4 entered at t_s4.
    function automatic logic [2:0] timeline(input int c, input int t_s1, input int t_s4);
        if (c < t_s1)     return 3'd0;
        if (c < t_s1 + 3) return 3'd1;
        if (c < t_s1 + 5) return 3'd2;
        if (c < t_s4)     return 3'd3;
        if (c < t_s4 + 3) return 3'd4;
        if (c < t_s4 + 5) return 3'd5;
        return 3'd0;
    endfunction

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic add(input logic clr, input logic xv, input logic req,
                       input logic [2:0] st, input logic ack);
        vec_t v;
        v.clr = clr; v.x = xv; v.req = req; v.st = st; v.ack = ack;
        vecs.push_back(v);
    endtask

    task automatic push_exp(input logic [2:0] st, input logic ack, input string tag);
        exp_t e;
        logic [5:0] l;
        l = lights(st);
        e.st = st; e.hwy = l[5:3]; e.crd = l[2:0];
        e.walk = (st == 3'd3); e.ack = ack; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic check_head();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard: got empty queue expected entry");
            return;
        end
        e = sb.pop_front();
        chk({e.tag, " state"}, state_o, e.st);
        chk({e.tag, " hwy"},   hwy,     e.hwy);
        chk({e.tag, " crd"},   crd,     e.crd);
        chk({e.tag, " walk"},  {2'b0, ped_walk}, {2'b0, e.walk});
        chk({e.tag, " ack"},   {2'b0, ped_ack},  {2'b0, e.ack});
    endtask

    task automatic run_vecs(input string name);
        vec_t v;
        int c;
        c = 0;
        while (vecs.size() > 0) begin
            v = vecs.pop_front();
            clear = v.clr; x = v.x; ped_req = v.req;
            push_exp(v.st, v.ack, $sformatf("%s c%0d", name, c));
            @(negedge clock);
            check_head();
            @(posedge clock);
            #1;
            c++;
        end
    endtask

    task automatic do_reset();
        clear = 1'b1; x = 1'b0; ped_req = 1'b0;
`ifdef EMERGENCY_PREEMPT_EN
        preempt = 1'b0;
`endif
        @(posedge clock);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        clear = 1'b1; x = 1'b1; ped_req = 1'b1;
`ifdef EMERGENCY_PREEMPT_EN
        preempt = 1'b0;
`endif
        // Reset held with busy inputs: lights stay S0, no ack.
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            push_exp(3'd0, 1'b0, $sformatf("reset c%0d", i));
            @(negedge clock);
            check_head();
        end

        // Idle: no car, no pedestrian, highway stays green.
        do_reset();
        for (int c = 0; c < 100; c++) add(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        run_vecs("idle");

        // Car arrives at cycle 2, leaves at cycle 20.
        do_reset();
        for (int c = 0; c < 30; c++)
            add(1'b0, (c >= 2 && c < 20), 1'b0, timeline(c, 8, 21), 1'b0);
        run_vecs("car");

        // Car held: country green capped at 16 cycles.
        do_reset();
        for (int c = 0; c < 42; c++)
            add(1'b0, 1'b1, 1'b0, timeline(c, 8, 29), 1'b0);
        run_vecs("maxgrn");

        // Pedestrians: accepted at 1, ignored at 4, same-cycle-as-clear at 12,
        // during walk at 15. After the round no request remains pending.
        do_reset();
        for (int c = 0; c < 37; c++)
            add(1'b0, 1'b0, (c == 1 || c == 4 || c == 12 || c == 15),
                timeline(c, 8, 21), (c == 2 || c == 13 || c == 16));
        run_vecs("ped");

        // Clear in S3 at timer 5 (cycle 18), then min-green restarts from 0.
        do_reset();
        for (int c = 0; c < 29; c++)
            add((c == 18), 1'b1, (c == 18),
                (c < 19) ? timeline(c, 8, 2000) : timeline(c - 19, 8, 2000), 1'b0);
        run_vecs("midclr");

`ifdef EMERGENCY_PREEMPT_EN
        // Preempt at S3 timer 2 cuts country green; S0 then held despite x.
        do_reset();
        for (int c = 0; c < 41; c++) begin
            x = 1'b1; ped_req = 1'b0; preempt = (c >= 15);
            push_exp(timeline(c, 8, 17), 1'b0, $sformatf("preempt c%0d", c));
            @(negedge clock);
            check_head();
            chk($sformatf("preempt_active c%0d", c), {2'b0, preempt_active}, {2'b0, (c >= 16)});
            @(posedge clock);
            #1;
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
